// File: rtl/model_encoder_ctrl.sv
// Sequencer for the big-encoder datapath: unpacks a word-wide weight stream
// into the serial copy/k interface, gates inference until a full weight image
// is loaded, and tracks in-flight samples with a valid shift pipeline.
module model_encoder_ctrl #(
    parameter int WEIGHTS_B = 61616,
    parameter int SW        = 8,
    parameter int PIPE_LAT  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start,
    input  logic                              w_valid,
    input  logic [SW-1:0]                     w_data,
    output logic                              w_ready,
    output logic                              copy,
    output logic                              k,
    output logic                              weights_ok,
    output logic                              load_busy,
    output logic                              load_done,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [$clog2(PIPE_LAT+1)-1:0]     inflight
);

    localparam int CNT_W = $clog2(WEIGHTS_B + 1);
    localparam int INF_W = $clog2(PIPE_LAT + 1);
    localparam int BIT_W = (SW > 1) ? $clog2(SW) : 1;

    typedef enum logic [2:0] {IDLE, DRAIN, WAIT_W, SHIFT, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [SW-1:0]       word;
    logic [CNT_W-1:0]    bits_left;
    logic [BIT_W-1:0]    bit_idx;
    logic [PIPE_LAT-1:0] vs;
    logic                last_bit;
    logic                word_end;
    logic                start_bits;

    assign last_bit   = (bits_left == CNT_W'(1));
    assign word_end   = (bit_idx == BIT_W'(SW - 1));
    assign start_bits = (state_nx == WAIT_W) && ((state == IDLE) || (state == DRAIN));

    // Count of valid samples currently travelling through the encoder pipeline.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + INF_W'(vs[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived handshake/shift outputs.
    always_comb begin
        state_nx  = state;
        w_ready   = 1'b0;
        copy      = 1'b0;
        k         = 1'b0;
        load_busy = 1'b1;
        load_done = 1'b0;
        in_ready  = 1'b0;
        out_valid = vs[PIPE_LAT-1];
        case (state)
            IDLE: begin
                load_busy = 1'b0;
                in_ready  = weights_ok & ~load_start;
                if (load_start) begin
                    state_nx = (inflight == '0) ? WAIT_W : DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nx = WAIT_W;
                end
            end
            WAIT_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                copy = 1'b1;
                k    = word[0];
                // The bit budget ends the load even part-way through a word.
                if (last_bit) begin
                    state_nx = DONE;
                end else if (word_end) begin
                    state_nx = WAIT_W;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Weight word unpacking, bit budget and image-complete flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            word       <= '0;
            bits_left  <= '0;
            bit_idx    <= '0;
            weights_ok <= 1'b0;
        end else begin
            if ((state == IDLE) && load_start) begin
                weights_ok <= 1'b0;
            end else if ((state == SHIFT) && last_bit) begin
                weights_ok <= 1'b1;
            end
            if (start_bits) begin
                bits_left <= CNT_W'(WEIGHTS_B);
            end
            if (w_ready && w_valid) begin
                word    <= w_data;
                bit_idx <= '0;
            end else if (state == SHIFT) begin
                word      <= word >> 1;
                bits_left <= bits_left - CNT_W'(1);
                bit_idx   <= bit_idx + BIT_W'(1);
            end
        end
    end

    // Valid pipeline mirroring the encoder's register stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs <= '0;
        end else begin
            vs[0] <= in_valid & in_ready;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vs[i] <= vs[i-1];
            end
        end
    end

    // Weights must never move while a sample is inside the encoder.
    a_no_copy_inflight: assert property (@(posedge clk) disable iff (rst)
        !(copy && (inflight != '0)));

endmodule

// File: tb/tb_model_encoder_ctrl.sv
// Directed bench for model_encoder_ctrl with a small weight image (20 bits,
// byte stream) and scoreboards for the serial k stream and sample latency.
module tb_model_encoder_ctrl;

    localparam int WB  = 20;
    localparam int SWB = 8;
    localparam int PL  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_start;
    logic           w_valid;
    logic [SWB-1:0] w_data;
    logic           w_ready;
    logic           copy;
    logic           k;
    logic           weights_ok;
    logic           load_busy;
    logic           load_done;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic [1:0]     inflight;

    model_encoder_ctrl #(.WEIGHTS_B(WB), .SW(SWB), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid),
        .w_data(w_data), .w_ready(w_ready), .copy(copy), .k(k),
        .weights_ok(weights_ok), .load_busy(load_busy), .load_done(load_done),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          kq[$];
    int          oq[$];
    int          copy_cnt = 0;
    int          done_cnt = 0;
    int          words_acc = 0;
    int          peak = 0;
    logic [WB-1:0] model = '0;
    logic [7:0]  words [3] = '{8'hA5, 8'h3C, 8'h0F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the k and latency scoreboards away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (copy) begin
                if (kq.size() == 0) check("copy_unexpected", {31'b0, copy}, 32'd0);
                else check("k_bit", {31'b0, k}, {31'b0, kq.pop_front()});
                copy_cnt++;
                model = {k, model[WB-1:1]};
            end
            if (load_done) done_cnt++;
            if (out_valid) begin
                if (oq.size() == 0) check("ov_unexpected", {31'b0, out_valid}, 32'd0);
                else check("ov_cycle", cyc, oq.pop_front());
            end
            if (in_valid && in_ready) oq.push_back(cyc + PL);
            if (int'(inflight) > peak) peak = int'(inflight);
        end
    end

    task automatic feed_word(input logic [7:0] wd, input int nbits);
        bit ok;
        int gap;
        gap = $urandom_range(0, 3);
        w_valid = 1'b0;
        repeat (gap) tick();
        w_valid = 1'b1;
        w_data  = wd;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            check("in_ready_busy", {31'b0, in_ready}, 32'd0);
            if (w_ready) begin
                ok = 1'b1;
                for (int b = 0; b < nbits; b++) kq.push_back(wd[b]);
                words_acc++;
            end
            tick();
        end
        w_valid = 1'b0;
        w_data  = 8'hEE;
        check("w_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic do_load(input bit with_sample, input bit restart_mid, input int exp_drain);
        bit got;
        int drain;
        int nb;
        copy_cnt = 0; done_cnt = 0; words_acc = 0; model = '0;
        load_start = 1'b1;
        in_valid = with_sample;
        @(negedge clk);
        if (with_sample) check("in_ready_vs_load", {31'b0, in_ready}, 32'd0);
        tick();
        load_start = 1'b0;
        in_valid = 1'b0;
        got = 1'b0;
        drain = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (n == 0 && with_sample) check("sample_rejected", {30'b0, inflight}, 32'd0);
            if (w_ready) got = 1'b1;
            else if (load_busy) begin
                drain++;
                check("copy_in_drain", {31'b0, copy}, 32'd0);
            end
            tick();
        end
        check("w_ready_seen", {31'b0, got}, 32'd1);
        check("drain_cycles", drain, exp_drain);
        for (int j = 0; j < 3; j++) begin
            nb = (WB - SWB * j > SWB) ? SWB : WB - SWB * j;
            feed_word(words[j], nb);
            if (restart_mid && j == 0) begin
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
            end
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (load_done) got = 1'b1;
            tick();
        end
        check("done_seen", {31'b0, got}, 32'd1);
        tick();
        @(negedge clk);
        check("copy_cycles", copy_cnt, WB);
        check("done_pulses", done_cnt, 1);
        check("words_accepted", words_acc, 3);
        check("weights_image", {12'b0, model}, 32'h000F3CA5);
        check("k_queue_empty", kq.size(), 0);
        check("weights_ok_after", {31'b0, weights_ok}, 32'd1);
        check("busy_after", {31'b0, load_busy}, 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; w_valid = 1'b0; w_data = '0; in_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs", {22'b0, w_ready, copy, k, weights_ok, load_busy,
              load_done, in_ready, out_valid, inflight}, 32'd0);
        tick();
        rst = 1'b0;
        // Samples offered before any weights exist are refused.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("in_ready_noload", {31'b0, in_ready}, 32'd0);
            tick();
        end
        check("out_valid_noload", {31'b0, out_valid}, 32'd0);
        check("weights_ok_noload", {31'b0, weights_ok}, 32'd0);
        in_valid = 1'b0;
        tick();

        // First load: pipeline empty, so no drain.
        do_load(1'b0, 1'b0, 0);

        // Five back-to-back samples.
        peak = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_ready_stream", {31'b0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("inflight_peak", peak, PL);
        check("ov_queue_drained", oq.size(), 0);

        // Load requested while one sample is still in flight.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        do_load(1'b0, 1'b0, 2);
        check("ov_queue_after_drain", oq.size(), 0);

        // Reset part-way through shifting.
        copy_cnt = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        feed_word(words[0], 8);
        feed_word(words[1], 8);
        for (int n = 0; n < 40 && copy_cnt < 10; n++) tick();
        check("reached_bit10", copy_cnt, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kq.delete();
        @(negedge clk);
        check("copy_after_rst", {31'b0, copy}, 32'd0);
        check("weights_ok_after_rst", {31'b0, weights_ok}, 32'd0);
        check("busy_after_rst", {31'b0, load_busy}, 32'd0);
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready_partial", {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        do_load(1'b0, 1'b0, 0);
        @(negedge clk);
        check("in_ready_reloaded", {31'b0, in_ready}, 32'd1);
        tick();

        // Load and sample in the same cycle, plus a redundant load_start mid-load.
        do_load(1'b1, 1'b1, 0);
        repeat (5) tick();
        check("ov_queue_final", oq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/model_encoder_ctrl.md
Name: model_encoder_ctrl

Overview:
- Sequencer for the big-encoder datapath: the serial TMR weight register (copy/k) and the 3-register inference pipeline.
- Unpacks a word-wide weight stream into the one-bit-per-cycle copy/k shift interface, and gates inference until a complete weight image is loaded.
- Tracks in-flight samples with a valid pipeline, and never shifts weights while samples are in flight.
- Sits between the host/DMA weight stream, the sample source, and the encoder instance.

Parameters:
- WEIGHTS_B, 61616, total weight bits in the encoder shift register.
- SW, 8, weight stream word width (bits).
- PIPE_LAT, 3, encoder latency: x sampled at edge t, y updated at edge t+PIPE_LAT-1.
- CNT_W, $clog2(WEIGHTS_B+1), bit-counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  request a full weight reload (pulse)
- w_valid  in  1  weight word valid
- w_data  in  SW  weight word; bit 0 is shifted first
- w_ready  out  1  weight word accepted when w_valid&w_ready
- copy  out  1  encoder shift enable
- k  out  1  encoder serial weight bit
- weights_ok  out  1  a complete image has been loaded since reset
- load_busy  out  1  high from load acceptance until load_done
- load_done  out  1  one-cycle pulse after the final bit is shifted
- in_valid  in  1  sample valid (x presented to encoder this cycle)
- in_ready  out  1  sample accepted when in_valid&in_ready
- out_valid  out  1  encoder y is valid this cycle
- inflight  out  $clog2(PIPE_LAT+1)  number of samples in the pipeline

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE. Valid pipeline is cleared.
  - All outputs go to 0: w_ready, copy, k, weights_ok, load_busy, load_done, in_ready, out_valid, inflight.
  - A reset mid-load abandons the load. weights_ok stays 0 until a later load completes.
- States:
  - IDLE: no load in progress.
  - DRAIN: load requested, waiting for the pipeline to empty.
  - WAIT_W: waiting for a weight word.
  - SHIFT: shifting the current word.
  - DONE: one cycle; load_done=1, weights_ok set.
- Transitions:
  - IDLE->DRAIN on load_start.
  - DRAIN->WAIT_W when inflight==0. Go directly to WAIT_W if inflight is already 0.
  - WAIT_W->SHIFT on w_valid&w_ready. The word is latched; w_ready=1 only in WAIT_W.
  - SHIFT: copy=1, k=word[0], word>>=1, bits_left-=1 every cycle.
    - After SW bits: go to WAIT_W if bits_left>0.
    - Go to DONE when bits_left reaches 0, even mid-word. Remaining upper bits of the last word are discarded (WEIGHTS_B%SW!=0 case).
  - DONE->IDLE.
- Bit counter: loaded with WEIGHTS_B on DRAIN->WAIT_W. The load takes exactly WEIGHTS_B cycles with copy=1 and ceil(WEIGHTS_B/SW) accepted words. copy=0 in every other state.
- Bit ordering: the encoder shifts in at the MSB, so the first bit streamed ends at weights_q[0] and the last at weights_q[WEIGHTS_B-1].
- weights_ok:
  - Cleared on load acceptance (IDLE->DRAIN->WAIT_W transition start), so a partial image is never used.
  - Set in DONE.
- load_busy=1 in DRAIN, WAIT_W, SHIFT, DONE.
- in_ready = weights_ok & (state==IDLE) & ~load_start. A load request blocks new samples in the same cycle.
- Valid pipeline: vs[0]<=in_valid&in_ready, vs[i]<=vs[i-1]. out_valid=vs[PIPE_LAT-1]; inflight=popcount(vs).
- Latency: sample accepted at edge t -> out_valid high in the cycle after edge t+PIPE_LAT-1. Full throughput is 1 sample/cycle, no bubbles.
- Simultaneous load_start and in_valid in IDLE: the load wins; the sample is not accepted.
- load_start while load_busy: ignored, no restart.
- w_valid outside WAIT_W: ignored; w_data is not consumed.
- copy is never 1 while inflight!=0. An assertion checks this.

Test Plan:
- Reset, then in_valid=1 with no load -> in_ready=0, out_valid stays 0. weights_ok=0. All outputs 0 after rst.
- WEIGHTS_B=20, SW=8, words 0xA5,0x3C,0x0F with random w_valid gaps:
  - copy high for exactly 20 cycles.
  - k sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1.
  - Third word upper nibble discarded; load_done one pulse; weights_ok=1.
  - Modelled register equals 0xF3CA5.
- After load, 5 back-to-back samples -> out_valid high for 5 consecutive cycles, the first 3 cycles after first acceptance. inflight peaks at 3.
- load_start one cycle after a sample accept:
  - State DRAIN for 2 cycles; copy stays 0 until inflight==0.
  - That sample's out_valid still appears; in_ready=0 throughout the load.
- rst asserted mid-SHIFT (bit 10 of 20) -> copy=0, weights_ok=0 next cycle. A fresh full load is then required before in_ready=1.
- load_start and in_valid in the same IDLE cycle -> sample rejected (vs[0]=0). load_start during load_busy -> bit count unchanged, no restart.
